// File: rtl/sa_pkg.sv
// sa_pkg: shared types and helpers for the systolic-array result drain.
package sa_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    localparam int WIDTH_DEF = 32;
    localparam int ACC_W     = 2 * WIDTH_DEF;

    // Accumulator width for a given operand width.
    function automatic int acc_w(input int width);
        return 2 * width;
    endfunction

    // Bit offset of accumulator (r,c) inside the flat YY / snapshot bus.
    function automatic int elem_off(input int r, input int c, input int hpe, input int width);
        return (r * hpe + c) * acc_w(width);
    endfunction

endpackage

// File: rtl/sa_sat_lane.sv
// sa_sat_lane: clamps one 2*WIDTH accumulator to the signed WIDTH-bit range
// and sign-extends the result back to 2*WIDTH bits; clip marks a clamped value.
module sa_sat_lane
    import sa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] sat,
    output logic               clip
);

    localparam int AW = acc_w(WIDTH);

    // The value fits iff the top WIDTH+1 bits are all copies of the sign bit.
    logic [WIDTH:0] hi;
    assign hi   = acc[AW-1:WIDTH-1];
    assign clip = !((&hi) || !(|hi));

    // Replace out-of-range values with the sign-appropriate limit.
    always_comb begin
        sat = acc;
        if (clip) begin
            if (acc[AW-1]) sat = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};
            else           sat = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
        end
    end

endmodule

// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots the array's accumulator bus on capture and streams
// it out one row per valid/ready transfer. Build option SA_DRAIN_SAT_EN adds
// per-element saturation on out_data and the sat_flag port.
//
//   state | meaning
//   IDLE  | no tile held; waiting for capture
//   DRAIN | snapshot held; row row_q presented on out_*
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int HPE   = 64,
    parameter int VPE   = 64,
    parameter int WIDTH = 32,
    parameter int ROW_W = (VPE > 1) ? $clog2(VPE) : 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [2*WIDTH*HPE*VPE-1:0]     YY,
    input  logic                           capture,
    input  logic                           out_ready,
    output logic [2*WIDTH*HPE-1:0]         out_data,
    output logic                           out_valid,
    output logic [ROW_W-1:0]               out_row,
    output logic                           out_last,
    output logic                           busy,
    output logic                           overrun
`ifdef SA_DRAIN_SAT_EN
    ,
    output logic [HPE-1:0]                 sat_flag
`endif
);

    localparam int               AW        = acc_w(WIDTH);
    localparam int               ROW_BITS  = HPE * AW;
    localparam int               TILE_BITS = ROW_BITS * VPE;
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(VPE - 1);

    drain_state_t         state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [TILE_BITS-1:0] snap_q;
    logic                 overrun_q;
    logic                 load;
    logic                 ovr_set;
    logic                 at_last;
    logic [ROW_BITS-1:0]  raw_row;

    assign at_last = (row_q == LAST_ROW);

    // Next state: a capture is accepted only when idle or on the final transfer.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        load    = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    load    = 1'b1;
                    row_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready && at_last) begin
                    row_d = '0;
                    if (capture) load    = 1'b1;
                    else         state_d = IDLE;
                end else begin
                    if (out_ready) row_d   = row_q + 1'b1;
                    if (capture)   ovr_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, row index and sticky overrun.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            row_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            if (ovr_set) overrun_q <= 1'b1;
        end
    end

    // Snapshot holds the tile so the array can start the next one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       snap_q <= '0;
        else if (load) snap_q <= YY;
    end

    assign raw_row   = snap_q[elem_off(int'(row_q), 0, HPE, WIDTH) +: ROW_BITS];
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == DRAIN);
    assign out_last  = out_valid && at_last;
    assign out_row   = row_q;
    assign overrun   = overrun_q;

`ifdef SA_DRAIN_SAT_EN
    for (genvar c = 0; c < HPE; c++) begin : g_sat
        sa_sat_lane #(.WIDTH(WIDTH)) u_lane (
            .acc  (raw_row[c*AW +: AW]),
            .sat  (out_data[c*AW +: AW]),
            .clip (sat_flag[c])
        );
    end
`else
    assign out_data = raw_row;
`endif

endmodule

// File: tb/tb_sa_result_drain.sv
// tb_sa_result_drain: randomized scenarios against a queue-of-rows reference model.
module tb_sa_result_drain;

    localparam int HPE   = 4;
    localparam int VPE   = 4;
    localparam int WIDTH = 32;
    localparam int AW    = 2 * WIDTH;
    localparam int RW    = HPE * AW;
    localparam int YYW   = RW * VPE;
    localparam int ROW_W = 2;

    localparam int HPE1 = 2;
    localparam int AW1  = 16;

    typedef struct {
        logic [RW-1:0]    data;
        logic [ROW_W-1:0] row;
        logic             last;
        logic [HPE-1:0]   flag;
    } row_t;

    logic             CLK;
    logic             RST;
    logic [YYW-1:0]   YY;
    logic             capture;
    logic             out_ready;
    logic [RW-1:0]    out_data;
    logic             out_valid;
    logic [ROW_W-1:0] out_row;
    logic             out_last;
    logic             busy;
    logic             overrun;

    logic [HPE1*AW1-1:0] yy1;
    logic                cap1;
    logic                rdy1;
    logic [HPE1*AW1-1:0] data1;
    logic                valid1;
    logic                row1;
    logic                last1;
    logic                busy1;
    logic                ovr1;

`ifdef SA_DRAIN_SAT_EN
    logic [HPE-1:0]  sat_flag;
    logic [HPE1-1:0] sat_flag1;
`endif

    row_t mq[$];
    bit   m_ovr;
    int   n_cmp;
    int   n_bad;

    sa_result_drain #(.HPE(HPE), .VPE(VPE), .WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .YY        (YY),
        .capture   (capture),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
`ifdef SA_DRAIN_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    sa_result_drain #(.HPE(HPE1), .VPE(1), .WIDTH(8)) dut1 (
        .CLK       (CLK),
        .RST       (RST),
        .YY        (yy1),
        .capture   (cap1),
        .out_ready (rdy1),
        .out_data  (data1),
        .out_valid (valid1),
        .out_row   (row1),
        .out_last  (last1),
        .busy      (busy1),
        .overrun   (ovr1)
`ifdef SA_DRAIN_SAT_EN
        ,
        .sat_flag  (sat_flag1)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected value of one element: raw, or clamped to signed WIDTH bits.
    function automatic logic [AW-1:0] exp_elem(input logic [AW-1:0] raw);
`ifdef SA_DRAIN_SAT_EN
        longint v, hi_lim, lo_lim;
        v      = longint'(raw);
        hi_lim = (longint'(1) <<< (WIDTH - 1)) - 1;
        lo_lim = -(longint'(1) <<< (WIDTH - 1));
        if (v > hi_lim) return AW'(hi_lim);
        if (v < lo_lim) return AW'(lo_lim);
        return raw;
`else
        return raw;
`endif
    endfunction

    function automatic logic [RW-1:0] exp_row(input logic [YYW-1:0] yy, input int r);
        logic [RW-1:0] d;
        for (int c = 0; c < HPE; c++) d[c*AW +: AW] = exp_elem(yy[(r*HPE + c)*AW +: AW]);
        return d;
    endfunction

    function automatic logic [HPE-1:0] exp_flag(input logic [YYW-1:0] yy, input int r);
        logic [HPE-1:0] f;
        for (int c = 0; c < HPE; c++)
            f[c] = (exp_elem(yy[(r*HPE + c)*AW +: AW]) != yy[(r*HPE + c)*AW +: AW]);
        return f;
    endfunction

    function automatic logic [YYW-1:0] rand_tile();
        logic [YYW-1:0] t;
        for (int i = 0; i < YYW / 32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    // Model of one rising edge: the row stream as a queue of pending rows.
    task automatic model_edge(input bit rdy, input bit cap, input logic [YYW-1:0] yy);
        bit xfer, fin, acc;
        row_t e;
        xfer = (mq.size() != 0) && rdy;
        fin  = xfer && mq[0].last;
        acc  = cap && ((mq.size() == 0) || fin);
        if (xfer) void'(mq.pop_front());
        if (cap && !acc) m_ovr = 1'b1;
        if (acc) begin
            for (int r = 0; r < VPE; r++) begin
                e.data = exp_row(yy, r);
                e.row  = ROW_W'(r);
                e.last = (r == VPE - 1);
                e.flag = exp_flag(yy, r);
                mq.push_back(e);
            end
        end
    endtask

    task automatic drive(input bit rdy, input bit cap, input logic [YYW-1:0] yy);
        out_ready = rdy;
        capture   = cap;
        YY        = yy;
        model_edge(rdy, cap, yy);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK);
        capture = 1'b1;
        YY      = rand_tile();
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
        n_cmp++; if (out_row !== 2'd0) begin n_bad++; $display("FAIL reset_row got %0d want 0", out_row); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", out_last); end
        n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL reset_valid1 got %b want 0", valid1); end
        capture = 1'b0;
        RST     = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release_valid got %b want 0", out_valid); end
    endtask

    task automatic test_basic();
        logic [YYW-1:0] t;
        for (int r = 0; r < VPE; r++)
            for (int c = 0; c < HPE; c++) t[(r*HPE + c)*AW +: AW] = AW'(16*r + c);
        drive(1'b1, 1'b1, t);
        for (int i = 0; i < VPE; i++) begin
            @(negedge CLK);
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid row%0d got %b want 1", i, out_valid); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy row%0d got %b want 1", i, busy); end
            n_cmp++; if (out_row !== ROW_W'(i)) begin n_bad++; $display("FAIL basic_row got %0d want %0d", out_row, i); end
            n_cmp++; if (out_last !== (i == VPE - 1)) begin n_bad++; $display("FAIL basic_last row%0d got %b", i, out_last); end
            n_cmp++; if (out_data !== mq[0].data) begin n_bad++; $display("FAIL basic_data row%0d got %h want %h", i, out_data, mq[0].data); end
            if (i == 2) begin
                n_cmp++;
                if (out_data !== {64'd35, 64'd34, 64'd33, 64'd32}) begin
                    n_bad++; $display("FAIL basic_row2_const got %h", out_data);
                end
            end
            drive(1'b1, 1'b0, rand_tile());
        end
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_end_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_end_busy got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        bit             pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit             rdy, stall;
        int             delivered;
        logic [RW-1:0]  prev_data;
        logic [ROW_W-1:0] prev_row;
        delivered = 0;
        stall     = 1'b0;
        drive(1'b1, 1'b1, rand_tile());
        for (int k = 0; k < 24; k++) begin
            @(negedge CLK);
            n_cmp++; if (out_valid !== (mq.size() != 0)) begin n_bad++; $display("FAIL bp_valid got %b want %b", out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_cmp++; if (out_data !== mq[0].data) begin n_bad++; $display("FAIL bp_data got %h want %h", out_data, mq[0].data); end
                n_cmp++; if (out_row !== mq[0].row) begin n_bad++; $display("FAIL bp_row got %0d want %0d", out_row, mq[0].row); end
                n_cmp++; if (out_last !== mq[0].last) begin n_bad++; $display("FAIL bp_last got %b want %b", out_last, mq[0].last); end
            end
            if (stall) begin
                n_cmp++; if (out_data !== prev_data || out_row !== prev_row) begin n_bad++; $display("FAIL bp_stable got row %0d want row %0d", out_row, prev_row); end
            end
            rdy       = pat[k % 4];
            stall     = out_valid && !rdy;
            prev_data = out_data;
            prev_row  = out_row;
            if (out_valid && rdy) delivered++;
            drive(rdy, 1'b0, rand_tile());
        end
        n_cmp++; if (delivered !== VPE) begin n_bad++; $display("FAIL bp_count got %0d want %0d", delivered, VPE); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_end_valid got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [YYW-1:0] aa;
        bit             fired, check_b;
        fired   = 1'b0;
        check_b = 1'b0;
        for (int i = 0; i < YYW / 8; i++) aa[i*8 +: 8] = 8'hAA;
        drive(1'b1, 1'b1, rand_tile());
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            n_cmp++; if (out_valid !== (mq.size() != 0)) begin n_bad++; $display("FAIL b2b_valid cyc%0d got %b want %b", k, out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_cmp++; if (out_data !== mq[0].data) begin n_bad++; $display("FAIL b2b_data got %h want %h", out_data, mq[0].data); end
                n_cmp++; if (out_row !== mq[0].row) begin n_bad++; $display("FAIL b2b_row got %0d want %0d", out_row, mq[0].row); end
                n_cmp++; if (out_last !== mq[0].last) begin n_bad++; $display("FAIL b2b_last got %b want %b", out_last, mq[0].last); end
            end
            n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL b2b_overrun got %b want %b", overrun, m_ovr); end
            if (check_b) begin
                n_cmp++; if (out_valid !== 1'b1 || out_row !== 2'd0 || out_data !== exp_row(aa, 0)) begin
                    n_bad++; $display("FAIL b2b_first_row got v%b r%0d %h", out_valid, out_row, out_data);
                end
                check_b = 1'b0;
            end
            if (!fired && out_valid && out_last) begin
                drive(1'b1, 1'b1, aa);
                fired   = 1'b1;
                check_b = 1'b1;
            end else begin
                drive(1'b1, 1'b0, rand_tile());
            end
        end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_no_overrun got %b want 0", overrun); end
    endtask

    task automatic test_overrun();
        logic [YYW-1:0] ta;
        bit             fired;
        fired = 1'b0;
        ta    = rand_tile();
        drive(1'b1, 1'b1, ta);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            n_cmp++; if (out_valid !== (mq.size() != 0)) begin n_bad++; $display("FAIL ovr_valid got %b want %b", out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_cmp++; if (out_data !== mq[0].data) begin n_bad++; $display("FAIL ovr_data got %h want %h", out_data, mq[0].data); end
                n_cmp++; if (out_row !== mq[0].row) begin n_bad++; $display("FAIL ovr_row got %0d want %0d", out_row, mq[0].row); end
            end
            n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL ovr_flag got %b want %b", overrun, m_ovr); end
            if (!fired && out_valid && out_row == 2'd1) begin
                drive(1'b1, 1'b1, rand_tile());
                fired = 1'b1;
            end else begin
                drive(1'b1, 1'b0, rand_tile());
            end
        end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", overrun); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_end_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 1'b0;
        drive(1'b1, 1'b1, rand_tile());
        for (int k = 0; k < 8 && !hit; k++) begin
            @(negedge CLK);
            if (out_valid && out_row == 2'd2) begin
                hit = 1'b1;
                drive(1'b0, 1'b0, rand_tile());
            end else begin
                drive(1'b1, 1'b0, rand_tile());
            end
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL rst_mid_reach got row %0d want 2", out_row); end
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_mid_overrun got %b want 0", overrun); end
        n_cmp++; if (out_row !== 2'd0) begin n_bad++; $display("FAIL rst_mid_row got %0d want 0", out_row); end
        mq.delete();
        m_ovr = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, rand_tile());
            @(negedge CLK);
            n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle got v%b b%b want 0", out_valid, busy); end
        end
    endtask

`ifdef SA_DRAIN_SAT_EN
    task automatic test_saturation();
        logic [YYW-1:0] t;
        t = rand_tile();
        t[0*AW +: AW] = 64'h0000_0001_0000_0000;
        t[1*AW +: AW] = 64'hFFFF_FFFF_0000_0000;
        t[2*AW +: AW] = 64'd5;
        t[3*AW +: AW] = -64'sd5;
        drive(1'b0, 1'b1, t);
        @(negedge CLK);
        n_cmp++; if (out_data !== {64'hFFFF_FFFF_FFFF_FFFB, 64'd5, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_7FFF_FFFF}) begin
            n_bad++; $display("FAIL sat_data got %h", out_data);
        end
        n_cmp++; if (sat_flag !== 4'b0011) begin n_bad++; $display("FAIL sat_flag got %b want 0011", sat_flag); end
        for (int k = 0; k < VPE; k++) begin
            n_cmp++; if (sat_flag !== mq[0].flag || out_data !== mq[0].data) begin n_bad++; $display("FAIL sat_row%0d flag %b want %b", k, sat_flag, mq[0].flag); end
            drive(1'b1, 1'b0, rand_tile());
            @(negedge CLK);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sat_end_valid got %b want 0", out_valid); end
    endtask
`endif

    task automatic test_stress();
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), rand_tile());
            @(negedge CLK);
            n_cmp++; if (out_valid !== (mq.size() != 0)) begin n_bad++; $display("FAIL stress_valid cyc%0d got %b want %b", k, out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_cmp++; if (out_data !== mq[0].data) begin n_bad++; $display("FAIL stress_data cyc%0d got %h want %h", k, out_data, mq[0].data); end
                n_cmp++; if (out_row !== mq[0].row) begin n_bad++; $display("FAIL stress_row cyc%0d got %0d want %0d", k, out_row, mq[0].row); end
                n_cmp++; if (out_last !== mq[0].last) begin n_bad++; $display("FAIL stress_last cyc%0d got %b want %b", k, out_last, mq[0].last); end
`ifdef SA_DRAIN_SAT_EN
                n_cmp++; if (sat_flag !== mq[0].flag) begin n_bad++; $display("FAIL stress_flag cyc%0d got %b want %b", k, sat_flag, mq[0].flag); end
`endif
            end
            n_cmp++; if (busy !== (mq.size() != 0)) begin n_bad++; $display("FAIL stress_busy cyc%0d got %b", k, busy); end
            n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL stress_overrun cyc%0d got %b want %b", k, overrun, m_ovr); end
        end
    endtask

    task automatic test_vpe1();
        logic [31:0] a, b;
        a = {16'hFFF0, 16'h0012};
        b = {16'hFF80, 16'h0003};
        cap1 = 1'b1; rdy1 = 1'b0; yy1 = a;
        @(negedge CLK);
        n_cmp++; if (valid1 !== 1'b1 || last1 !== 1'b1 || row1 !== 1'b0) begin n_bad++; $display("FAIL v1_first got v%b l%b r%b want 1 1 0", valid1, last1, row1); end
        n_cmp++; if (data1 !== a) begin n_bad++; $display("FAIL v1_data got %h want %h", data1, a); end
        cap1 = 1'b1; rdy1 = 1'b0; yy1 = 32'h1234_5678;
        @(negedge CLK);
        n_cmp++; if (data1 !== a) begin n_bad++; $display("FAIL v1_stall_data got %h want %h", data1, a); end
        n_cmp++; if (ovr1 !== 1'b1) begin n_bad++; $display("FAIL v1_overrun got %b want 1", ovr1); end
        cap1 = 1'b1; rdy1 = 1'b1; yy1 = b;
        @(negedge CLK);
        n_cmp++; if (valid1 !== 1'b1 || last1 !== 1'b1 || data1 !== b) begin n_bad++; $display("FAIL v1_b2b got v%b l%b %h want 1 1 %h", valid1, last1, data1, b); end
        cap1 = 1'b0; rdy1 = 1'b1; yy1 = a;
        @(negedge CLK);
        n_cmp++; if (valid1 !== 1'b0 || busy1 !== 1'b0) begin n_bad++; $display("FAIL v1_end got v%b b%b want 0 0", valid1, busy1); end
        n_cmp++; if (ovr1 !== 1'b1) begin n_bad++; $display("FAIL v1_sticky got %b want 1", ovr1); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        m_ovr     = 1'b0;
        RST       = 1'b1;
        capture   = 1'b0;
        out_ready = 1'b0;
        YY        = '0;
        cap1      = 1'b0;
        rdy1      = 1'b0;
        yy1       = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
`ifdef SA_DRAIN_SAT_EN
        test_saturation();
`endif
        test_stress();
        drive(1'b1, 1'b0, rand_tile());
        test_vpe1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
